// File: rtl/bcd_mod_counter_if.sv
// rtl/bcd_mod_counter_if.sv - control and count bus of the BCD modulo counter
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);
  logic                  enable;
  logic                  set_mode;
  logic                  set_key;
  logic                  down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  carry;
  logic                  borrow;
  logic                  load_error;

  // Driver side: the lower stage / user controls and observer of the count
  modport master (
    output enable, set_mode, set_key, down, load, load_value,
    input  count_bcd, carry, borrow, load_error
  );

  // Counter side
  modport slave (
    input  enable, set_mode, set_key, down, load, load_value,
    output count_bcd, carry, borrow, load_error
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - native packed-BCD modulo counter with set key, load and carry/borrow
module bcd_mod_counter #(
  parameter int DIGITS    = 2,
  parameter int MIN_VALUE = 0,
  parameter int MAX_VALUE = 59
) (
  input logic              clock,
  input logic              reset,
  bcd_mod_counter_if.slave bus
);

  localparam int W = 4 * DIGITS;

  // Decimal integer to packed BCD, digit 0 in the low nibble
  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VALUE);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);
  // For valid BCD the packed value orders like the decimal value, so the
  // range check can be done as one unsigned offset compare.
  localparam logic [W-1:0] SPAN    = MAX_BCD - MIN_BCD;

  // Every digit 0..9 and value within [MIN_VALUE, MAX_VALUE]
  function automatic logic is_legal(input logic [W-1:0] x);
    logic         ok;
    logic [W-1:0] offset;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (x[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    offset = x - MIN_BCD;
    if (offset > SPAN) ok = 1'b0;
    return ok;
  endfunction

  // Ripple increment: a digit at 9 rolls to 0 and passes the carry on
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         c;
    r = x;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (x[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = x[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple decrement: a digit at 0 rolls to 9 and passes the borrow on
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         b;
    r = x;
    b = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (b) begin
        if (x[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = x[4*d +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_q;
  logic         carry_q;
  logic         borrow_q;
  logic         load_error_q;
  logic         key_meta;
  logic         key_sync;
  logic         key_prev;
  logic         key_rise;
  logic         step;

  // Edge detection looks only at key level history, so toggling set_mode
  // while the key is held cannot fabricate a step.
  assign key_rise = key_sync & ~key_prev;
  assign step     = bus.set_mode ? key_rise : bus.enable;

  // Key synchroniser, load/step/hold of the count and single-cycle pulses
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q      <= MIN_BCD;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      load_error_q <= 1'b0;
      key_meta     <= 1'b0;
      key_sync     <= 1'b0;
      key_prev     <= 1'b0;
    end else begin
      key_meta     <= bus.set_key;
      key_sync     <= key_meta;
      key_prev     <= key_sync;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      load_error_q <= 1'b0;
      if (bus.load) begin
        if (is_legal(bus.load_value)) begin
          count_q <= bus.load_value;
        end else begin
          load_error_q <= 1'b1;
        end
      end else if (step) begin
        if (!is_legal(count_q)) begin
          // Upset state: recover quietly, never disturb the next stage
          count_q <= MIN_BCD;
        end else if (!bus.down) begin
          if (count_q == MAX_BCD) begin
            count_q <= MIN_BCD;
            carry_q <= ~bus.set_mode;
          end else begin
            count_q <= bcd_inc(count_q);
          end
        end else begin
          if (count_q == MIN_BCD) begin
            count_q  <= MAX_BCD;
            borrow_q <= ~bus.set_mode;
          end else begin
            count_q <= bcd_dec(count_q);
          end
        end
      end
    end
  end

  assign bus.count_bcd  = count_q;
  assign bus.carry      = carry_q;
  assign bus.borrow     = borrow_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - directed self-checking bench for bcd_mod_counter
module tb_bcd_mod_counter;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  bcd_mod_counter_if #(.DIGITS(2)) a_if ();
  bcd_mod_counter_if #(.DIGITS(2)) b_if ();

  bcd_mod_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(59)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if)
  );

  bcd_mod_counter #(.DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(31)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    a_if.load       = 1'b1;
    a_if.load_value = v;
    tick();
    a_if.load       = 1'b0;
  endtask

  task automatic enable_a();
    a_if.enable = 1'b1;
    tick();
    a_if.enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (a_if.count_bcd !== 8'h00) begin tests_failed++; $display("FAIL reset_count_a got %h want 00", a_if.count_bcd); end
    tests_run++;
    if (b_if.count_bcd !== 8'h01) begin tests_failed++; $display("FAIL reset_count_b got %h want 01", b_if.count_bcd); end
    tests_run++;
    if ({a_if.carry, a_if.borrow, a_if.load_error} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_pulses got %b want 000", {a_if.carry, a_if.borrow, a_if.load_error});
    end
    reset = 1'b1;
  endtask

  task automatic test_mod60();
    logic [7:0] exp;
    a_if.enable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp = 8'((((k % 60) / 10) * 16) + ((k % 60) % 10));
      tests_run++;
      if (a_if.count_bcd !== exp) begin tests_failed++; $display("FAIL mod60_count k=%0d got %h want %h", k, a_if.count_bcd, exp); end
      tests_run++;
      if (a_if.carry !== (k == 60)) begin tests_failed++; $display("FAIL mod60_carry k=%0d got %b want %b", k, a_if.carry, (k == 60)); end
      tests_run++;
      if (a_if.borrow !== 1'b0) begin tests_failed++; $display("FAIL mod60_borrow k=%0d got %b want 0", k, a_if.borrow); end
    end
    a_if.enable = 1'b0;
  endtask

  task automatic test_min_one();
    b_if.load = 1'b1; b_if.load_value = 8'h31;
    tick();
    b_if.load = 1'b0;
    tests_run++;
    if (b_if.count_bcd !== 8'h31) begin tests_failed++; $display("FAIL min1_load got %h want 31", b_if.count_bcd); end
    b_if.enable = 1'b1;
    tick();
    b_if.enable = 1'b0;
    tests_run++;
    if (b_if.count_bcd !== 8'h01 || b_if.carry !== 1'b1) begin
      tests_failed++; $display("FAIL min1_upwrap got %h/%b want 01/1", b_if.count_bcd, b_if.carry);
    end
    tick();
    tests_run++;
    if (b_if.carry !== 1'b0) begin tests_failed++; $display("FAIL min1_carry_len got %b want 0", b_if.carry); end
    b_if.down = 1'b1; b_if.enable = 1'b1;
    tick();
    b_if.enable = 1'b0; b_if.down = 1'b0;
    tests_run++;
    if (b_if.count_bcd !== 8'h31 || b_if.borrow !== 1'b1 || b_if.carry !== 1'b0) begin
      tests_failed++; $display("FAIL min1_downwrap got %h/%b/%b want 31/1/0", b_if.count_bcd, b_if.borrow, b_if.carry);
    end
    b_if.load = 1'b1; b_if.load_value = 8'h00;
    tick();
    b_if.load = 1'b0;
    tests_run++;
    if (b_if.count_bcd !== 8'h31 || b_if.load_error !== 1'b1) begin
      tests_failed++; $display("FAIL min1_below_min got %h/%b want 31/1", b_if.count_bcd, b_if.load_error);
    end
    b_if.load = 1'b1; b_if.load_value = 8'h32;
    tick();
    b_if.load = 1'b0;
    tests_run++;
    if (b_if.count_bcd !== 8'h31 || b_if.load_error !== 1'b1) begin
      tests_failed++; $display("FAIL min1_above_max got %h/%b want 31/1", b_if.count_bcd, b_if.load_error);
    end
  endtask

  task automatic test_load_error();
    load_a(8'h5A);
    tests_run++;
    if (a_if.count_bcd !== 8'h00 || a_if.load_error !== 1'b1) begin
      tests_failed++; $display("FAIL load_5a got %h/%b want 00/1", a_if.count_bcd, a_if.load_error);
    end
    load_a(8'h60);
    tests_run++;
    if (a_if.count_bcd !== 8'h00 || a_if.load_error !== 1'b1) begin
      tests_failed++; $display("FAIL load_60 got %h/%b want 00/1", a_if.count_bcd, a_if.load_error);
    end
    load_a(8'h45);
    tests_run++;
    if (a_if.count_bcd !== 8'h45 || a_if.load_error !== 1'b0) begin
      tests_failed++; $display("FAIL load_45 got %h/%b want 45/0", a_if.count_bcd, a_if.load_error);
    end
  endtask

  task automatic test_ripple();
    load_a(8'h09);
    enable_a();
    tests_run++;
    if (a_if.count_bcd !== 8'h10) begin tests_failed++; $display("FAIL ripple_09_up got %h want 10", a_if.count_bcd); end
    load_a(8'h10);
    a_if.down = 1'b1;
    enable_a();
    tests_run++;
    if (a_if.count_bcd !== 8'h09) begin tests_failed++; $display("FAIL ripple_10_down got %h want 09", a_if.count_bcd); end
    a_if.down = 1'b0;
    load_a(8'h19);
    enable_a();
    tests_run++;
    if (a_if.count_bcd !== 8'h20) begin tests_failed++; $display("FAIL ripple_19_up got %h want 20", a_if.count_bcd); end
    load_a(8'h00);
    a_if.down = 1'b1;
    enable_a();
    a_if.down = 1'b0;
    tests_run++;
    if (a_if.count_bcd !== 8'h59 || a_if.borrow !== 1'b1) begin
      tests_failed++; $display("FAIL ripple_00_down got %h/%b want 59/1", a_if.count_bcd, a_if.borrow);
    end
  endtask

  task automatic test_set_key();
    logic [7:0] exp;
    load_a(8'h59);
    a_if.set_mode = 1'b1;
    a_if.enable   = 1'b1;
    a_if.set_key  = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = (e < 3) ? 8'h59 : 8'h00;
      tests_run++;
      if (a_if.count_bcd !== exp || a_if.carry !== 1'b0) begin
        tests_failed++; $display("FAIL set_key edge=%0d got %h/%b want %h/0", e, a_if.count_bcd, a_if.carry, exp);
      end
    end
    a_if.set_key = 1'b0;
    a_if.enable  = 1'b0;
    tick();
    a_if.set_mode = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if (a_if.count_bcd !== 8'h00) begin tests_failed++; $display("FAIL set_key_release got %h want 00", a_if.count_bcd); end
  endtask

  task automatic test_back_to_back();
    load_a(8'h58);
    a_if.load = 1'b1; a_if.enable = 1'b1; a_if.load_value = 8'h20;
    tick();
    a_if.load = 1'b0; a_if.enable = 1'b0;
    tests_run++;
    if (a_if.count_bcd !== 8'h20 || a_if.carry !== 1'b0) begin
      tests_failed++; $display("FAIL load_beats_step got %h/%b want 20/0", a_if.count_bcd, a_if.carry);
    end
    load_a(8'h59);
    reset = 1'b0; a_if.enable = 1'b1;
    tick();
    tests_run++;
    if (a_if.count_bcd !== 8'h00 || a_if.carry !== 1'b0) begin
      tests_failed++; $display("FAIL reset_beats_step got %h/%b want 00/0", a_if.count_bcd, a_if.carry);
    end
    tests_run++;
    if (b_if.count_bcd !== 8'h01) begin tests_failed++; $display("FAIL reset_mid_b got %h want 01", b_if.count_bcd); end
    reset = 1'b1; a_if.enable = 1'b0;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    a_if.enable = 1'b0; a_if.set_mode = 1'b0; a_if.set_key = 1'b0;
    a_if.down = 1'b0; a_if.load = 1'b0; a_if.load_value = 8'h00;
    b_if.enable = 1'b0; b_if.set_mode = 1'b0; b_if.set_key = 1'b0;
    b_if.down = 1'b0; b_if.load = 1'b0; b_if.load_value = 8'h00;
    #1;
    test_reset();
    test_mod60();
    test_min_one();
    test_load_error();
    test_ripple();
    test_set_key();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised native-BCD modulo counter for the clock/calendar chain: seconds, minutes, hours, days and months. It counts directly in packed BCD across DIGITS digits, with no binary-to-BCD stage. It supports a non-zero minimum value (days/months start at 1), up/down direction, parallel load and a debounced-edge set key. It emits one-cycle carry/borrow pulses to cascade into the next stage.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS
MIN_VALUE, 0, lowest count value (decimal); wrap target when counting up
MAX_VALUE, 59, highest count value (decimal); wrap target when counting down; must be > MIN_VALUE and < 10**DIGITS

Ports:
clock  input  1  single system clock; all state changes on rising edge
reset  input  1  synchronous, active-low; sampled on rising clock edge
enable  input  1  one-cycle count tick from lower stage (normal mode)
set_mode  input  1  1 = manual set mode; steps come from set_key, not enable
set_key  input  1  raw asynchronous key level (active-high)
down  input  1  0 = count up, 1 = count down
load  input  1  one-cycle parallel-load strobe
load_value  input  4*DIGITS  packed BCD value to load
count_bcd  output  4*DIGITS  current count, packed BCD, digit 0 in bits [3:0]
carry  output  1  one-cycle pulse on up-wrap MAX_VALUE->MIN_VALUE
borrow  output  1  one-cycle pulse on down-wrap MIN_VALUE->MAX_VALUE
load_error  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset==0 at clock edge): count_bcd=MIN_VALUE in BCD; carry=borrow=load_error=0; key synchroniser and edge flops cleared to 0.
- Key path: 2-flop synchroniser, then a previous-value flop. key_rise = sync_out & ~prev. Raw key rising edge to count change is 3 clock edges. A held key produces exactly one step.
- step = set_mode ? key_rise : enable. enable is ignored while set_mode=1; key_rise is ignored while set_mode=0.
- Per-edge priority: reset > load > step > hold.
- Load: accepted if every digit <=9 and MIN_VALUE<=value<=MAX_VALUE. Accepted: count_bcd=load_value next cycle. Rejected: count holds and load_error=1 for one cycle. A step in the same cycle as load is dropped.
- Up step: if count==MAX_VALUE, count<=MIN_VALUE and carry<=1 (only if set_mode==0). Otherwise BCD ripple increment: digit 9->0 with +1 to the next digit.
- Down step: if count==MIN_VALUE, count<=MAX_VALUE and borrow<=1 (only if set_mode==0). Otherwise BCD ripple decrement: digit 0->9 with -1 to the next digit.
- Set mode never produces carry/borrow, so adjusting one field does not disturb higher stages.
- carry/borrow are registered. They are high in exactly the cycle in which count_bcd first shows the wrapped value, and low in all other cycles.
- Illegal internal state (digit >9 or out of range; only reachable by SEU) is corrected to MIN_VALUE on the next step, with no pulse.
- down may change on any cycle; it is sampled only in a cycle that has a step.
- If set_mode toggles while the key is held, no spurious step occurs, because edge detection is level-history based.
- Mid-operation reset overrides load, step and pending pulses in the same edge.
- count_bcd is always a legal BCD value in [MIN_VALUE, MAX_VALUE].

Test Plan:
1. Defaults (60-mod), reset=0 for 2 cycles then release; apply 60 enable pulses -> count 00,01..59,00; carry=1 only in the cycle count shows 00; borrow never set.
2. DIGITS=2, MIN_VALUE=1, MAX_VALUE=31; load 8'h31, one enable -> count 8'h01 with carry=1. down=1, one enable -> 8'h31 with borrow=1.
3. Load 8'h5A, then 8'h60, then 8'h45 -> first two hold the count with load_error pulses; third gives count 8'h45 and load_error=0.
4. set_mode=1, enable held high, set_key asserted for 10 cycles -> exactly one step, 3 edges after key rise. Stepping from 59 to 00 -> carry stays 0.
5. BCD ripple: load 8'h09, enable -> 8'h10. load 8'h10, down=1, enable -> 8'h09. load 8'h19, enable -> 8'h20.
6. Same-cycle load=1 and enable=1 at count 8'h58 with load_value 8'h20 -> 8'h20, no carry. Then reset=0 coincident with enable at 8'h59 -> 8'h00 and carry=0.
